// File: rtl/sp_sram_pkg.sv
// sp_sram_pkg: shared FSM state type and bank/row address decode helpers
package sp_sram_pkg;
  typedef enum logic [1:0] {SRAM_RUN, SRAM_DRAIN, SRAM_CLR} sram_state_e;
  function automatic logic [31:0] bank_sel(input logic [31:0] addr, input logic interleave, input int aw, input int bsel);
    return interleave ? addr & ((32'd1 << bsel) - 32'd1) : addr >> (aw - bsel);
  endfunction
  function automatic logic [31:0] bank_row(input logic [31:0] addr, input logic interleave, input int aw, input int bsel);
    return interleave ? addr >> bsel : addr & ((32'd1 << (aw - bsel)) - 32'd1);
  endfunction
endpackage

// File: rtl/sp_sram_bank_slice.sv
// sp_sram_bank_slice: one single-port macro (en/we/be in, 1-cycle registered read data out, ctrl pass-through)
module sp_sram_bank_slice #(
  parameter int DW      = 32,
  parameter int BANK_AW = 6,
  parameter int CTRL_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [DW/8-1:0]    be_i,
  input  logic [BANK_AW-1:0] addr_i,
  input  logic [DW-1:0]      wdata_i,
  input  logic [CTRL_W-1:0]  ctrl_i,
  output logic [DW-1:0]      rdata_o
);
  logic [DW-1:0] mem_q [2**BANK_AW];
  logic [DW-1:0] rdata_q;
  logic          unused_ctrl;
  assign unused_ctrl = ^ctrl_i;
  assign rdata_o = rdata_q;
  always_ff @(posedge clk) begin
    if (en_i && we_i)
      for (int i = 0; i < DW/8; i++)
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end
endmodule

// File: rtl/sp_sram_banked.sv
// sp_sram_banked: NUM_BANKS single-port slices behind one valid/ready port with bank decode, zero-clear FSM and read-response pipe
module sp_sram_banked import sp_sram_pkg::*; #(
  parameter int DW             = 32,
  parameter int AW             = 16,
  parameter int NUM_BANKS      = 4,
  parameter int INTERLEAVE     = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CTRL_W         = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AW-1:0]     req_addr_i,
  input  logic              req_we_i,
  input  logic [DW/8-1:0]   req_be_i,
  input  logic [DW-1:0]     req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DW-1:0]     rsp_rdata_o,
  input  logic              clr_start_i,
  output logic              busy_o,
  input  logic [CTRL_W-1:0] ram_ctrl_i
);
  localparam int BSEL    = $clog2(NUM_BANKS);
  localparam int BANK_AW = AW - BSEL;
  sram_state_e        state_q, state_d;
  logic [BANK_AW-1:0] cnt_q, cnt_d;
  logic               rd_v_q;
  logic [BSEL-1:0]    rd_bank_q;
  logic [BSEL-1:0]    sel;
  logic [BANK_AW-1:0] row;
  logic               accept, clr, pend, inflight;
  logic [DW-1:0]      rdata [NUM_BANKS];
  logic [DW-1:0]      mux_rdata;
  assign sel         = BSEL'(bank_sel(32'(req_addr_i), INTERLEAVE != 0, AW, BSEL));
  assign row         = BANK_AW'(bank_row(32'(req_addr_i), INTERLEAVE != 0, AW, BSEL));
  assign clr         = rst_n && state_q == SRAM_CLR;
  assign req_ready_o = rst_n && state_q == SRAM_RUN && !clr_start_i;
  assign busy_o      = state_q != SRAM_RUN;
  assign accept      = req_valid_i && req_ready_o;
  assign mux_rdata   = rdata[rd_bank_q];
  assign inflight    = rd_v_q || pend;
  always_comb begin
    state_d = state_q == SRAM_RUN   ? (clr_start_i ? SRAM_DRAIN : SRAM_RUN) :
              state_q == SRAM_DRAIN ? (inflight ? SRAM_DRAIN : SRAM_CLR) :
              (&cnt_q ? SRAM_RUN : SRAM_CLR);
    cnt_d   = state_q == SRAM_CLR ? cnt_q + BANK_AW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? SRAM_CLR : SRAM_RUN;
      cnt_q     <= '0;
      rd_v_q    <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_v_q  <= accept && !req_we_i;
      if (accept && !req_we_i) rd_bank_q <= sel;
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic          rsp_v_q;
    logic [DW-1:0] rsp_d_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rsp_v_q <= 1'b0;
        rsp_d_q <= '0;
      end else begin
        rsp_v_q <= rd_v_q;
        if (rd_v_q) rsp_d_q <= mux_rdata;
      end
    end
    assign rsp_valid_o = rsp_v_q;
    assign rsp_rdata_o = rsp_d_q;
    assign pend        = rsp_v_q;
  end else begin : g_noreg
    assign rsp_valid_o = rd_v_q;
    assign rsp_rdata_o = mux_rdata;
    assign pend        = 1'b0;
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sp_sram_bank_slice #(.DW(DW), .BANK_AW(BANK_AW), .CTRL_W(CTRL_W)) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (clr || (accept && sel == BSEL'(b) && (!req_we_i || |req_be_i))),
      .we_i    (clr || req_we_i),
      .be_i    (clr ? '1 : req_be_i),
      .addr_i  (clr ? cnt_q : row),
      .wdata_i (clr ? '0 : req_wdata_i),
      .ctrl_i  (ram_ctrl_i),
      .rdata_o (rdata[b])
    );
  end
endmodule

// File: tb/tb_sp_sram_banked.sv
// tb_sp_sram_banked: block- and interleaved/out-reg instances driven in lockstep against a word-level memory model
module tb_sp_sram_banked;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        clr_start = 1'b0;
  logic [4:0]  ram_ctrl = 5'h0b;
  logic        rdy [2];
  logic        rsp_v [2];
  logic [31:0] rsp_d [2];
  logic        busy [2];
  logic        bz [2];
  logic [31:0] mem [2][256];
  int          busy_left [2];
  logic        prev_rd [2];
  logic        p1v [2];
  logic [31:0] p1d [2];
  logic        ev [2];
  logic [31:0] ed [2];
  int          ncmp = 0;
  int          nfail = 0;
  always #5 clk = ~clk;
  sp_sram_banked #(.DW(32), .AW(8), .NUM_BANKS(4), .INTERLEAVE(0), .OUT_REG(0), .CLEAR_ON_RESET(1), .CTRL_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[0]), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_v[0]),
    .rsp_rdata_o(rsp_d[0]), .clr_start_i(clr_start), .busy_o(busy[0]), .ram_ctrl_i(ram_ctrl));
  sp_sram_banked #(.DW(32), .AW(8), .NUM_BANKS(4), .INTERLEAVE(1), .OUT_REG(1), .CLEAR_ON_RESET(1), .CTRL_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[1]), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_v[1]),
    .rsp_rdata_o(rsp_d[1]), .clr_start_i(clr_start), .busy_o(busy[1]), .ram_ctrl_i(ram_ctrl));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset(input int k);
    busy_left[k] = 64;
    prev_rd[k] = 1'b0;
    p1v[k] = 1'b0;
    p1d[k] = '0;
    ev[k] = 1'b0;
    ed[k] = '0;
    for (int a = 0; a < 256; a++) mem[k][a] = '0;
  endtask
  task automatic cyc();
    logic acc [2];
    logic rd;
    logic r_exp;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      r_exp = rst_n && busy_left[k] == 0 && !clr_start;
      chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(r_exp));
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(busy_left[k] != 0));
      bz[k] = busy[k];
      acc[k] = req_valid && r_exp;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      else begin
        rd = acc[k] && !req_we;
        if (k == 1) begin
          ev[k] = p1v[k];
          if (p1v[k]) ed[k] = p1d[k];
          p1v[k] = rd;
          if (rd) p1d[k] = mem[k][req_addr];
        end else begin
          ev[k] = rd;
          if (rd) ed[k] = mem[k][req_addr];
        end
        if (acc[k] && req_we)
          for (int i = 0; i < 4; i++)
            if (req_be[i]) mem[k][req_addr][8*i +: 8] = req_wdata[8*i +: 8];
        if (busy_left[k] > 0) busy_left[k]--;
        else if (clr_start) begin
          busy_left[k] = 64 + ((k == 1 && prev_rd[k]) ? 2 : 1);
          for (int a = 0; a < 256; a++) mem[k][a] = '0;
        end
        prev_rd[k] = rd;
      end
      chk($sformatf("rsp_valid%0d", k), 32'(rsp_v[k]), 32'(ev[k]));
      chk($sformatf("rsp_rdata%0d", k), rsp_d[k], ed[k]);
    end
  endtask
  task automatic set_idle();
    req_valid = 1'b0;
    req_we = 1'b0;
    req_be = '0;
    clr_start = 1'b0;
  endtask
  task automatic req(input logic we, input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_be = be;
    req_wdata = d;
    cyc();
    set_idle();
  endtask
  task automatic count_busy(input string tag, input int exp0, input int exp1);
    int n0 = 0;
    int n1 = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      n0 += int'(bz[0]);
      n1 += int'(bz[1]);
      if (!bz[0] && !bz[1]) break;
    end
    chk({tag, "_u0"}, n0, exp0);
    chk({tag, "_u1"}, n1, exp1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  initial begin
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    cyc();
    cyc();
    rst_n = 1'b1;
    count_busy("reset_clear_len", 64, 64);
    req(1'b0, 8'h00, 4'h0, '0);
    req(1'b0, 8'h3F, 4'h0, '0);
    req(1'b0, 8'h40, 4'h0, '0);
    req(1'b0, 8'hFF, 4'h0, '0);
    idle(3);
    req(1'b1, 8'h41, 4'hF, 32'hA5A5A5A5);
    chk("u0_bank1_row1", u0.g_bank[1].u_slice.mem_q[1], 32'hA5A5A5A5);
    chk("u0_bank0_row1", u0.g_bank[0].u_slice.mem_q[1], 32'h0);
    chk("u1_bank1_row16", u1.g_bank[1].u_slice.mem_q[16], 32'hA5A5A5A5);
    req(1'b0, 8'h41, 4'h0, '0);
    chk("rd41_u0_lat1", rsp_d[0], 32'hA5A5A5A5);
    idle(3);
    for (int a = 0; a < 4; a++) req(1'b1, 8'(a), 4'hF, $urandom);
    for (int a = 0; a < 4; a++) req(1'b0, 8'(a), 4'h0, '0);
    idle(3);
    req(1'b1, 8'h10, 4'hF, 32'hFFFFFFFF);
    req(1'b1, 8'h10, 4'b0010, 32'h00001200);
    req(1'b0, 8'h10, 4'h0, '0);
    chk("be_merge_u0", rsp_d[0], 32'hFFFF12FF);
    req(1'b1, 8'h10, 4'h0, 32'h0);
    req(1'b0, 8'h10, 4'h0, '0);
    idle(3);
    chk("be0_keep_u1", rsp_d[1], 32'hFFFF12FF);
    req(1'b0, 8'h41, 4'h0, '0);
    clr_start = 1'b1;
    req(1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
    count_busy("drain_clear_len", 65, 66);
    req(1'b0, 8'h10, 4'h0, '0);
    idle(3);
    chk("after_clear_u1", rsp_d[1], 32'h0);
    req(1'b1, 8'h05, 4'hF, 32'h12345678);
    idle(2);
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    idle(21);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    count_busy("reset_mid_clear_len", 64, 64);
    req(1'b0, 8'h05, 4'h0, '0);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      req_valid = $urandom_range(0, 3) != 0;
      req_we = $urandom_range(0, 1) != 0;
      req_addr = 8'($urandom);
      req_be = 4'($urandom);
      req_wdata = $urandom;
      clr_start = $urandom_range(0, 59) == 0;
      cyc();
    end
    set_idle();
    idle(70);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
